softusb_dbgport: RTL

SOFTUSB_DBGPORT -- requirements
Module: softusb_dbgport

---
 rtl/softusb_dbgport_if.sv | 17 +
 rtl/softusb_dbgport.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/softusb_dbgport_if.sv
// softusb_dbgport_if
// navre I/O bus bundle seen by the debug port.
//   io_re : read strobe (CPU -> port)
//   io_we : write strobe (CPU -> port)
//   io_a  : 6-bit I/O address (CPU -> port)
//   io_do : write data (CPU -> port)
//   io_di : registered read data (port -> CPU)
interface softusb_dbgport_if;
    logic       io_re;
    logic       io_we;
    logic [5:0] io_a;
    logic [7:0] io_do;
    logic [7:0] io_di;

    modport master (output io_re, output io_we, output io_a, output io_do, input io_di);
    modport slave  (input io_re, input io_we, input io_a, input io_do, output io_di);
endinterface

// File: rtl/softusb_dbgport.sv
// softusb_dbgport
// Firmware debug port: the navre CPU writes bytes into a small FIFO that a
// host drains through a valid/ready stream. It also carries a sticky
// overflow flag and an end-of-test "done" flag.
// Register map (io_a[1:0] once io_a[5:2] matches io_base[5:2]):
//   0 DATA   : write pushes a byte, read returns the head byte (no pop)
//   1 STATUS : {done, 4'b0, ovf, empty, full}, read-only
//   2 CTRL   : 8'hFE sets done, 8'h00 clears done,
//              otherwise bit0 clears ovf and bit1 flushes the FIFO
//   3 LEVEL  : occupancy zero-extended to 8 bits, read-only
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   io            : navre I/O bus (slave side)
//   out_data      : FIFO head byte, out_valid : FIFO non-empty
//   out_ready     : host accepts the head byte this cycle
//   level         : FIFO occupancy, done : firmware end-of-test flag
module softusb_dbgport #(
    parameter int          depth_log2 = 4,
    parameter logic [5:0]  io_base    = 6'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    softusb_dbgport_if.slave      io,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [depth_log2:0]   level,
    output logic                  done
);

    localparam int                  depth_c   = 1 << depth_log2;
    localparam logic [depth_log2:0] full_c    = (depth_log2+1)'(depth_c);
    localparam logic [depth_log2:0] lvl_one_c = (depth_log2+1)'(1'b1);
    localparam logic [depth_log2-1:0] ptr_one_c = depth_log2'(1'b1);

    logic [7:0]            mem_r [depth_c];
    logic [depth_log2-1:0] wr_ptr_r;
    logic [depth_log2-1:0] rd_ptr_r;
    logic [depth_log2:0]   level_r;
    logic                  ovf_r;
    logic                  done_r;
    logic [7:0]            io_di_r;

    logic       sel_s;
    logic       empty_s;
    logic       full_s;
    logic       pop_s;
    logic       push_s;
    logic       drop_s;
    logic       flush_s;
    logic       clr_ovf_s;
    logic       set_done_s;
    logic       clr_done_s;
    logic [7:0] level8_s;
    logic [7:0] rd_data_s;

    assign out_data  = mem_r[rd_ptr_r];
    assign out_valid = ~empty_s;
    assign level     = level_r;
    assign done      = done_r;
    assign io.io_di  = io_di_r;

    // Address decode, FIFO handshake qualification and CTRL command decode.
    always_comb begin
        sel_s      = (io.io_a[5:2] == io_base[5:2]);
        empty_s    = (level_r == '0);
        full_s     = (level_r == full_c);
        pop_s      = out_ready & ~empty_s;
        push_s     = 1'b0;
        drop_s     = 1'b0;
        flush_s    = 1'b0;
        clr_ovf_s  = 1'b0;
        set_done_s = 1'b0;
        clr_done_s = 1'b0;
        if (io.io_we && sel_s) begin
            case (io.io_a[1:0])
                2'd0: begin
                    // A full FIFO only takes a byte when a pop frees a slot.
                    push_s = ~full_s | pop_s;
                    drop_s = full_s & ~pop_s;
                end
                2'd2: begin
                    if (io.io_do == 8'hFE) begin
                        set_done_s = 1'b1;
                    end else if (io.io_do == 8'h00) begin
                        clr_done_s = 1'b1;
                    end else begin
                        clr_ovf_s = io.io_do[0];
                        flush_s   = io.io_do[1];
                    end
                end
                default: begin
                    push_s = 1'b0;
                end
            endcase
        end else begin
            push_s = 1'b0;
        end
    end

    // Read-data mux; undecoded cycles return zero so io_di can be OR-ed.
    always_comb begin
        level8_s                 = 8'h00;
        level8_s[depth_log2:0]   = level_r;
        rd_data_s                = 8'h00;
        if (io.io_re && sel_s) begin
            case (io.io_a[1:0])
                2'd0:    rd_data_s = out_data;
                2'd1:    rd_data_s = {done_r, 4'b0000, ovf_r, empty_s, full_s};
                2'd2:    rd_data_s = 8'h00;
                2'd3:    rd_data_s = level8_s;
                default: rd_data_s = 8'h00;
            endcase
        end else begin
            rd_data_s = 8'h00;
        end
    end

    // FIFO storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_s && !flush_s) begin
            mem_r[wr_ptr_r] <= io.io_do;
        end
    end

    // Pointers, occupancy, flags and registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            ovf_r    <= 1'b0;
            done_r   <= 1'b0;
            io_di_r  <= 8'h00;
        end else begin
            io_di_r <= rd_data_s;
            if (flush_s) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                level_r  <= '0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + ptr_one_c;
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + ptr_one_c;
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
                case ({push_s, pop_s})
                    2'b10:   level_r <= level_r + lvl_one_c;
                    2'b01:   level_r <= level_r - lvl_one_c;
                    default: level_r <= level_r;
                endcase
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (clr_ovf_s) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
            if (set_done_s) begin
                done_r <= 1'b1;
            end else if (clr_done_s) begin
                done_r <= 1'b0;
            end else begin
                done_r <= done_r;
            end
        end
    end

endmodule
